// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM (loads, stores, OP-IMM, OP, branches)
//
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over a shared datapath,
// owns the memory req/ready handshake and traps on illegal opcodes or a
// stalled memory (watchdog of MEM_TIMEOUT wait cycles).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_i           IR contents, valid from DECODE onward
//   br_cond_i         branch compare result, used in EXEC
//   mem_ready_i       memory completes the current request this cycle
//   mem_req_o/mem_we_o/addr_sel_o   memory request, store flag, address select
//   ir_we_o, pc_we_o, pc_sel_o      IR latch, PC update, PC+4 / PC+imm
//   reg_we_o, wb_sel_o              regfile write enable, ALU / memory data
//   alu_src_imm_o, alu_mode_o       ALU operand B select, 00 ADD 01 FUNCT 10 CMP
//   state_o                         FSM state for debug
//   trap_o, trap_cause_o            halted flag, 01 illegal 10 fetch TO 11 mem TO
//   instret_o                       retired-instruction count
//                                   (only with MULTICYCLE_CTRL_PERF_EN defined)
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_i,
    input  logic              br_cond_i,
    input  logic              mem_ready_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              addr_sel_o,
    output logic              ir_we_o,
    output logic              pc_we_o,
    output logic              pc_sel_o,
    output logic              reg_we_o,
    output logic              wb_sel_o,
    output logic              alu_src_imm_o,
    output logic [1:0]        alu_mode_o,
    output logic [2:0]        state_o,
    output logic              trap_o,
    output logic [1:0]        trap_cause_o
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  instret_o
`endif
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
    } state_e;
    typedef enum logic [2:0] {C_BR, C_LD, C_ST, C_IMM, C_REG} cls_e;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    state_e      state_q, state_d;
    cls_e        cls_q, cls_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]  cause_q, cause_d;
    logic        timeout;
    logic        unused_instr;
    assign unused_instr = ^instr_i[31:12];
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // the wait cycle in which the counter already sits at the limit is the
    // last chance for ready; ready in that cycle still wins
    assign timeout = cnt_q >= TIMEOUT;
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        cause_d       = cause_q;
        cnt_d         = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        addr_sel_o    = 1'b0;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        pc_sel_o      = 1'b0;
        reg_we_o      = 1'b0;
        wb_sel_o      = 1'b0;
        alu_src_imm_o = 1'b0;
        alu_mode_o    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
                else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else cnt_d = cnt_inc;
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (instr_i[6:0])
                    7'b1100011: cls_d = C_BR;
                    7'b0000011: cls_d = C_LD;
                    7'b0100011: cls_d = C_ST;
                    7'b0010011: cls_d = C_IMM;
                    7'b0110011: cls_d = C_REG;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                pc_we_o  = cls_q == C_BR;
                pc_sel_o = (cls_q == C_BR) && br_cond_i;
                state_d  = (cls_q == C_BR) ? S_FETCH :
                           (cls_q == C_LD || cls_q == C_ST) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                mem_we_o   = cls_q == C_ST;
                if (mem_ready_i) begin
                    pc_we_o = cls_q == C_ST;
                    state_d = (cls_q == C_ST) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b11;
                end else cnt_d = cnt_inc;
            end
            S_WB: begin
                reg_we_o = |instr_i[11:7];
                wb_sel_o = cls_q == C_LD;
                pc_we_o  = 1'b1;
                state_d  = S_FETCH;
            end
            default: ;
        endcase
        // ALU controls are set in EXEC and held through MEM/WB
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_mode_o    = (cls_q == C_BR) ? 2'b10 :
                            (cls_q == C_LD || cls_q == C_ST) ? 2'b00 : 2'b01;
            alu_src_imm_o = cls_q != C_BR && cls_q != C_REG;
        end
        // the state register already sits in FETCH during reset; mask its strobes
        if (!rst_n) begin
            {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_sel_o} = '0;
            {reg_we_o, wb_sel_o, alu_src_imm_o, alu_mode_o} = '0;
        end
    end
    assign state_o      = state_q;
    assign trap_o       = state_q == S_TRAP;
    assign trap_cause_o = cause_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_BR;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] instret_q, instret_d;
    // pc_we is never raised in TRAP, so the count freezes there
    assign instret_d = instret_q + CNT_W'(pc_we_o);
    assign instret_o = instret_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= '0;
        else        instret_q <= instret_d;
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        br_cond, mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src_imm;
    logic [1:0]  alu_mode, trap_cause;
    logic [2:0]  state;
    logic        trap;
    logic [16:0] obs;
    int          n_cmp = 0, n_err = 0, ret = 0;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret;
`endif
    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .br_cond_i(br_cond), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .addr_sel_o(addr_sel), .ir_we_o(ir_we),
        .pc_we_o(pc_we), .pc_sel_o(pc_sel), .reg_we_o(reg_we), .wb_sel_o(wb_sel),
        .alu_src_imm_o(alu_src_imm), .alu_mode_o(alu_mode), .state_o(state),
        .trap_o(trap), .trap_cause_o(trap_cause)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .instret_o(instret)
`endif
    );
    always #5 clk = ~clk;
    assign obs = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                  alu_src_imm, alu_mode, trap, trap_cause};
    function automatic logic [16:0] ev(input logic [2:0] st, input logic req, we, asel, irwe,
                                       pcwe, pcsel, regwe, wbsel, src, input logic [1:0] mode,
                                       input logic tr, input logic [1:0] cause);
        return {st, req, we, asel, irwe, pcwe, pcsel, regwe, wbsel, src, mode, tr, cause};
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_ret(input string tag);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk(tag, 64'(instret), 64'(ret));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask
    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction
    task automatic cyc(input string tag, input logic rdy, input logic [16:0] exp);
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, 64'(obs), 64'(exp));
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("reset", 64'(obs), 64'(0));
        ret = 0;
        chk_ret("instret_reset");
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask
    task automatic trap_seq(input logic [1:0] cause);
        for (int k = 0; k < 3; k++)
            cyc("trap", rnd_bit(), ev(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, cause));
        chk_ret("instret_trap");
        do_reset();
    endtask
    // c: 0 BR, 1 LD, 2 ST, 3 IMM, 4 REG, 5 illegal
    function automatic logic [31:0] mk(input int c);
        logic [31:0] r = $urandom();
        logic [6:0]  op;
        op = (c == 0) ? 7'b1100011 : (c == 1) ? 7'b0000011 : (c == 2) ? 7'b0100011 :
             (c == 3) ? 7'b0010011 : (c == 4) ? 7'b0110011 : 7'b1111111;
        return {r[31:7], op};
    endfunction
    task automatic run_instr(input int c, input logic [31:0] enc, input logic brc,
                             input int df, input int dm, input int rst_at);
        logic [1:0] mode = (c == 0) ? 2'b10 : (c == 1 || c == 2) ? 2'b00 : 2'b01;
        logic       src  = (c == 1 || c == 2 || c == 3);
        logic       rdy;
        instr = enc;
        br_cond = brc;
        for (int k = 0; k <= TO; k++) begin
            rdy = (k == df);
            cyc("fetch", rdy, ev(3'd0, 1, 0, 0, rdy, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
            if (rdy) break;
        end
        if (df > TO) begin
            trap_seq(2'b10);
            return;
        end
        cyc("decode", rnd_bit(), ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        if (c == 5) begin
            trap_seq(2'b01);
            return;
        end
        cyc("exec", rnd_bit(), ev(3'd2, 0, 0, 0, 0, c == 0, c == 0 && brc, 0, 0, src, mode, 0, 2'b00));
        if (c == 0) begin
            ret++;
            chk_ret("instret_br");
            return;
        end
        if (c == 1 || c == 2) begin
            for (int k = 0; k <= TO; k++) begin
                if (k == rst_at) begin
                    do_reset();
                    return;
                end
                rdy = (k == dm);
                cyc("mem", rdy, ev(3'd3, 1, c == 2, 1, 0, rdy && c == 2, 0, 0, 0, src, mode, 0, 2'b00));
                if (rdy) break;
            end
            if (dm > TO) begin
                trap_seq(2'b11);
                return;
            end
            if (c == 2) begin
                ret++;
                chk_ret("instret_st");
                return;
            end
        end
        cyc("wb", rnd_bit(), ev(3'd4, 0, 0, 0, 0, 1, 0, enc[11:7] != 5'd0, c == 1, src, mode, 0, 2'b00));
        ret++;
        chk_ret("instret_wb");
    endtask
    function automatic int rnd_delay();
        return ($urandom_range(0, 15) == 0) ? TO + 1 : int'($urandom_range(0, TO));
    endfunction
    initial begin
        rst_n = 1'b0;
        instr = '0;
        br_cond = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset_init", 64'(obs), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(3, 32'h00700293, 0, 0, 0, -1);
        run_instr(2, 32'h00602423, 0, 0, 0, -1);
        run_instr(0, 32'h00000463, 1, 0, 0, -1);
        chk_ret("instret_three");
        run_instr(0, 32'h00000463, 0, 0, 0, -1);
        run_instr(1, 32'h00402303, 0, 0, 3, -1);
        run_instr(4, 32'h00000033, 0, 1, 0, -1);
        run_instr(3, mk(3), 0, TO, 0, -1);
        run_instr(1, mk(1), 0, 0, TO, -1);
        run_instr(3, mk(3), 0, TO + 1, 0, -1);
        run_instr(5, 32'h0000007F, 0, 0, 0, -1);
        run_instr(2, mk(2), 0, 0, TO + 1, -1);
        run_instr(1, 32'h00402303, 0, 0, TO + 1, 2);
        for (int i = 0; i < 300; i++) begin
            int c = ($urandom_range(0, 19) == 0) ? 5 : int'($urandom_range(0, 4));
            run_instr(c, mk(c), rnd_bit(), rnd_delay(), rnd_delay(),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
